disk_track_loader: RTL and testbench

//  Multi-drive track cache filler: loads whole disk tracks from SD block images into track RAM.

---
 rtl/disk_loader_pkg.sv | 22 ++
 rtl/disk_loader_arb.sv | 28 ++
 rtl/disk_track_loader.sv | 202 ++++++++++++++++++++
 tb/tb_disk_track_loader.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/disk_loader_pkg.sv
// disk_loader_pkg
//   Shared types and helpers for the disk track loader.
//   state_t      : loader FSM states (IDLE, READ, FLUSH)
//   SECTOR_BYTES : size of one SD block / track RAM sector
//   track_lba()  : first SD block of a track, zero-extended product
package disk_loader_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      FLUSH = 2'd2
   } state_t;

   localparam int unsigned SECTOR_BYTES = 512;

   // Wide result; callers truncate to their own sd_lba width.
   function automatic logic [63:0] track_lba(input logic [31:0] trk,
                                             input logic [31:0] secs);
      return 64'(trk) * 64'(secs);
   endfunction

endpackage

// File: rtl/disk_loader_arb.sv
// disk_loader_arb
//   Fixed-priority pick over pending drive requests, lowest index wins.
//   Purely combinational.
//   req   : per-drive pending flags
//   valid : at least one request pending
//   idx   : index of the lowest pending request (0 when none)
module disk_loader_arb #(
   parameter int unsigned N     = 2,
   parameter int unsigned IDX_W = 1
) (
   input  logic [N-1:0]     req,
   output logic             valid,
   output logic [IDX_W-1:0] idx
);

   always_comb begin
      valid = 1'b0;
      idx   = '0;
      // Scan downwards so the lowest set bit is the last one written.
      for (int unsigned i = N; i > 0; i--) begin
         if (req[i-1]) begin
            valid = 1'b1;
            idx   = IDX_W'(i - 1);
         end
      end
   end

endmodule

// File: rtl/disk_track_loader.sv
// disk_track_loader
//   Multi-drive track cache filler. Loads whole disk tracks from SD block
//   images into track RAM whenever a drive's head track changes or a new
//   image is mounted, and stalls the CPU while the track is unavailable.
//
//   Ports:
//     clk_sys      system clock
//     reset_n      asynchronous active-low reset
//     track        head track per drive, drive d at [d*TRACK_W +: TRACK_W]
//     img_mounted  1-cycle mount pulse per drive
//     img_valid    image present per drive
//     sd_lba       SD block address of the transfer in progress
//     sd_rd        per-drive read request (one-hot or zero)
//     sd_wr        per-drive write request (one-hot or zero)
//     sd_ack       per-drive block acknowledge from hps_io
//     dirty        per-drive track RAM modified flag
//     dirty_clr    1-cycle pulse when a drive's flush has completed
//     cur_drive    drive owning the SD port / track RAM bank select
//     track_sec    sector index within the track (high track RAM address)
//     cpu_wait     CPU stall request
//     busy         loader not idle
//
//   Build option: define TRACK_WRITEBACK_EN to write a dirty track back to
//   its image before loading the new one. Without it sd_wr and dirty_clr
//   stay 0 and dirty is ignored.
module disk_track_loader
   import disk_loader_pkg::*;
#(
   parameter int unsigned DRIVES         = 2,
   parameter int unsigned TRACK_W        = 6,
   parameter int unsigned SECS_PER_TRACK = 13,
   parameter int unsigned LBA_W          = 32,
   parameter int unsigned WAIT_FULL      = 1,
   localparam int unsigned DRV_W = (DRIVES > 1) ? $clog2(DRIVES) : 1,
   localparam int unsigned SEC_W = (SECS_PER_TRACK > 1) ? $clog2(SECS_PER_TRACK) : 1
) (
   input  logic                        clk_sys,
   input  logic                        reset_n,
   input  logic [DRIVES*TRACK_W-1:0]   track,
   input  logic [DRIVES-1:0]           img_mounted,
   input  logic [DRIVES-1:0]           img_valid,
   output logic [LBA_W-1:0]            sd_lba,
   output logic [DRIVES-1:0]           sd_rd,
   output logic [DRIVES-1:0]           sd_wr,
   input  logic [DRIVES-1:0]           sd_ack,
   input  logic [DRIVES-1:0]           dirty,
   output logic [DRIVES-1:0]           dirty_clr,
   output logic [DRV_W-1:0]            cur_drive,
   output logic [SEC_W-1:0]            track_sec,
   output logic                        cpu_wait,
   output logic                        busy
);

   localparam logic [SEC_W-1:0] LAST_SEC = SEC_W'(SECS_PER_TRACK - 1);

   state_t                state, state_n;
   logic [TRACK_W-1:0]    cur_track   [DRIVES];
   logic [TRACK_W-1:0]    cur_track_n [DRIVES];
   logic [TRACK_W-1:0]    trk_in      [DRIVES];
   logic [DRIVES-1:0]     need, need_n, mismatch;
   logic [DRIVES-1:0]     ack_q;
   logic [DRIVES-1:0]     sd_rd_n, sd_wr_n, dirty_clr_n;
   logic [LBA_W-1:0]      sd_lba_n;
   logic [DRV_W-1:0]      cur_drive_n;
   logic [SEC_W-1:0]      track_sec_n;
   logic                  cpu_wait_n;
   logic                  pick_valid;
   logic [DRV_W-1:0]      pick_idx;
   logic                  ack_rise, ack_fall, xfer_on;

`ifndef TRACK_WRITEBACK_EN
   logic [DRIVES-1:0]     unused_dirty;
   assign unused_dirty = dirty;
`endif

   disk_loader_arb #(
      .N     (DRIVES),
      .IDX_W (DRV_W)
   ) u_arb (
      .req   (need),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   always_comb begin
      for (int unsigned d = 0; d < DRIVES; d++) begin
         trk_in[d]   = track[d*TRACK_W +: TRACK_W];
         mismatch[d] = (trk_in[d] != cur_track[d]);
      end
   end

   // Only the owning drive's acknowledge is observed.
   assign ack_rise = sd_ack[cur_drive] & ~ack_q[cur_drive];
   assign ack_fall = ~sd_ack[cur_drive] & ack_q[cur_drive];
   assign xfer_on  = |(sd_rd | sd_wr);
   assign busy     = (state != IDLE);

   always_comb begin
      state_n     = state;
      cur_track_n = cur_track;
      need_n      = need | mismatch | img_mounted;
      sd_lba_n    = sd_lba;
      sd_rd_n     = sd_rd;
      sd_wr_n     = sd_wr;
      dirty_clr_n = '0;
      cur_drive_n = cur_drive;
      track_sec_n = track_sec;
      cpu_wait_n  = cpu_wait;

      case (state)
         IDLE: begin
            if (pick_valid) begin
               cur_track_n[pick_idx] = trk_in[pick_idx];
               // A mount arriving in the service cycle stays pending.
               need_n[pick_idx]      = img_mounted[pick_idx];
               if (img_valid[pick_idx]) begin
                  cur_drive_n = pick_idx;
                  track_sec_n = '0;
                  cpu_wait_n  = 1'b1;
`ifdef TRACK_WRITEBACK_EN
                  if (dirty[pick_idx]) begin
                     // Flush goes to the track that is still in RAM.
                     sd_lba_n          = LBA_W'(track_lba(32'(cur_track[pick_idx]),
                                                          32'(SECS_PER_TRACK)));
                     sd_wr_n[pick_idx] = 1'b1;
                     state_n           = FLUSH;
                  end else
`endif
                  begin
                     sd_lba_n          = LBA_W'(track_lba(32'(trk_in[pick_idx]),
                                                          32'(SECS_PER_TRACK)));
                     sd_rd_n[pick_idx] = 1'b1;
                     state_n           = READ;
                  end
               end
            end
         end

         default: begin
            if (ack_rise) begin
               sd_lba_n = sd_lba + LBA_W'(1);
               if (track_sec == LAST_SEC) begin
                  sd_rd_n = '0;
                  sd_wr_n = '0;
               end
            end else if (ack_fall) begin
               if (!xfer_on) begin
                  // Final sector done; track_sec stays on the last sector.
`ifdef TRACK_WRITEBACK_EN
                  if (state == FLUSH) begin
                     dirty_clr_n[cur_drive] = 1'b1;
                     sd_lba_n               = LBA_W'(track_lba(32'(cur_track[cur_drive]),
                                                               32'(SECS_PER_TRACK)));
                     sd_rd_n[cur_drive]     = 1'b1;
                     track_sec_n            = '0;
                     state_n                = READ;
                  end else
`endif
                  begin
                     cpu_wait_n = 1'b0;
                     state_n    = IDLE;
                  end
               end else begin
                  track_sec_n = track_sec + SEC_W'(1);
                  if (WAIT_FULL == 0 && state == READ && track_sec == '0)
                     cpu_wait_n = 1'b0;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         for (int unsigned d = 0; d < DRIVES; d++)
            cur_track[d] <= '0;
         need      <= '0;
         ack_q     <= '0;
         sd_lba    <= '0;
         sd_rd     <= '0;
         sd_wr     <= '0;
         dirty_clr <= '0;
         cur_drive <= '0;
         track_sec <= '0;
         cpu_wait  <= 1'b0;
      end else begin
         state     <= state_n;
         cur_track <= cur_track_n;
         need      <= need_n;
         ack_q     <= sd_ack;
         sd_lba    <= sd_lba_n;
         sd_rd     <= sd_rd_n;
         sd_wr     <= sd_wr_n;
         dirty_clr <= dirty_clr_n;
         cur_drive <= cur_drive_n;
         track_sec <= track_sec_n;
         cpu_wait  <= cpu_wait_n;
      end
   end

endmodule

// File: tb/tb_disk_track_loader.sv
// tb_disk_track_loader
//   Directed bench for disk_track_loader: a WAIT_FULL=1 instance (u_dut)
//   and a WAIT_FULL=0 instance (u_nowait) share all inputs. A host model
//   answers sd_rd/sd_wr with sd_ack pulses; each expected sector transfer
//   is queued when stimulus is applied and compared at its ack.
module tb_disk_track_loader;

   typedef struct packed {
      logic [0:0]  drv;
      logic [1:0]  rd;
      logic [1:0]  wr;
      logic [31:0] lba;
      logic [3:0]  sec;
   } xfer_t;

   logic        clk_sys = 1'b0;
   logic        reset_n;
   logic [11:0] track;
   logic [1:0]  img_mounted, img_valid, sd_ack, dirty;

   logic [31:0] a_sd_lba, b_sd_lba;
   logic [1:0]  a_sd_rd, a_sd_wr, a_dirty_clr, b_sd_rd, b_sd_wr, b_dirty_clr;
   logic [0:0]  a_cur_drive, b_cur_drive;
   logic [3:0]  a_track_sec, b_track_sec;
   logic        a_cpu_wait, a_busy, b_cpu_wait, b_busy;

   int          checks = 0;
   int          failures = 0;
   int          clr_count = 0;
   int          inv_err = 0;
   xfer_t       exp_q[$];

   always #5 clk_sys = ~clk_sys;

   disk_track_loader #(.DRIVES(2), .TRACK_W(6), .SECS_PER_TRACK(13),
                       .LBA_W(32), .WAIT_FULL(1)) u_dut (
      .clk_sys(clk_sys), .reset_n(reset_n), .track(track),
      .img_mounted(img_mounted), .img_valid(img_valid),
      .sd_lba(a_sd_lba), .sd_rd(a_sd_rd), .sd_wr(a_sd_wr), .sd_ack(sd_ack),
      .dirty(dirty), .dirty_clr(a_dirty_clr), .cur_drive(a_cur_drive),
      .track_sec(a_track_sec), .cpu_wait(a_cpu_wait), .busy(a_busy));

   disk_track_loader #(.DRIVES(2), .TRACK_W(6), .SECS_PER_TRACK(13),
                       .LBA_W(32), .WAIT_FULL(0)) u_nowait (
      .clk_sys(clk_sys), .reset_n(reset_n), .track(track),
      .img_mounted(img_mounted), .img_valid(img_valid),
      .sd_lba(b_sd_lba), .sd_rd(b_sd_rd), .sd_wr(b_sd_wr), .sd_ack(sd_ack),
      .dirty(dirty), .dirty_clr(b_dirty_clr), .cur_drive(b_cur_drive),
      .track_sec(b_track_sec), .cpu_wait(b_cpu_wait), .busy(b_busy));

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_load(input int drv, input bit wr, input int trk);
      xfer_t e;
      for (int i = 0; i < 13; i++) begin
         e.drv = 1'(drv);
         e.rd  = wr ? 2'b00 : (2'b01 << drv);
         e.wr  = wr ? (2'b01 << drv) : 2'b00;
         e.lba = 32'(trk * 13 + i);
         e.sec = 4'(i);
         exp_q.push_back(e);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk_sys);
   endtask

   task automatic pulse_mount(input logic [1:0] m);
      img_mounted = m;
      @(negedge clk_sys);
      img_mounted = 2'b00;
   endtask

   task automatic wait_busy(input string tag);
      int n = 0;
      while (!a_busy && n < 200) begin @(negedge clk_sys); n++; end
      check({tag, "_busy"}, 64'(a_busy), 64'd1);
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while ((a_busy || exp_q.size() != 0) && n < 5000) begin @(negedge clk_sys); n++; end
      check({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
      check({tag, "_idle"}, 64'(a_busy), 64'd0);
   endtask

   // Host: request seen -> 2 cycles -> ack high 3 cycles -> low, 2-cycle gap.
   initial begin : host
      int unsigned phase;
      logic [1:0]  req;
      xfer_t       obs, ex;
      phase  = 0;
      req    = 2'b00;
      sd_ack = 2'b00;
      forever begin
         @(posedge clk_sys); #1;
         if (!reset_n) begin
            phase  = 0;
            sd_ack = 2'b00;
         end else begin
            case (phase)
               0: if ((a_sd_rd | a_sd_wr) != 2'b00) begin
                     req   = a_sd_rd | a_sd_wr;
                     phase = 1;
                  end
               1: phase = 2;
               2: begin
                     obs = {a_cur_drive, a_sd_rd, a_sd_wr, a_sd_lba, a_track_sec};
                     if (exp_q.size() == 0)
                        check("xfer_unexpected", 64'(obs), 64'd0);
                     else begin
                        ex = exp_q.pop_front();
                        check("xfer", 64'(obs), 64'(ex));
                     end
                     sd_ack = req;
                     phase  = 3;
                  end
               3, 4: phase++;
               5: begin sd_ack = 2'b00; phase = 6; end
               6: phase = 7;
               default: phase = 0;
            endcase
         end
      end
   end

   initial begin : monitor
      forever begin
         @(posedge clk_sys); #1;
         if (a_dirty_clr[0]) clr_count++;
         if (a_cpu_wait !== a_busy) inv_err++;
      end
   end

   initial begin : watchdog
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      bit saw_busy, saw_rd, saw_wait;
      int n;

      reset_n = 1'b0; track = '0; img_valid = 2'b01; img_mounted = 2'b00; dirty = 2'b00;
      tick(3);
      check("rst_lba", 64'(a_sd_lba), 64'd0);
      check("rst_rd_wr", 64'({a_sd_rd, a_sd_wr, b_sd_rd, b_sd_wr}), 64'd0);
      check("rst_clr", 64'({a_dirty_clr, b_dirty_clr}), 64'd0);
      check("rst_drive_sec", 64'({a_cur_drive, a_track_sec, b_cur_drive, b_track_sec}), 64'd0);
      check("rst_wait_busy", 64'({a_cpu_wait, a_busy, b_cpu_wait, b_busy}), 64'd0);
      reset_n = 1'b1;
      tick(5);
      check("idle_after_rst", 64'(a_busy), 64'd0);

      // Track 0 -> 5 on drive 0: blocks 65..77.
      push_load(0, 0, 5);
      track[5:0] = 6'd5;
      wait_busy("t1");
      check("t1_wait_full", 64'(a_cpu_wait), 64'd1);
      check("t1_wait_nofull", 64'(b_cpu_wait), 64'd1);
      n = 0;
      while (b_cpu_wait && n < 300) begin @(negedge clk_sys); n++; end
      check("t2_release_sec", 64'(b_track_sec), 64'd1);
      check("t2_rd_held", 64'(b_sd_rd), 64'd1);
      check("t2_full_still_wait", 64'(a_cpu_wait), 64'd1);
      wait_done("t1");
      check("t1_lba_end", 64'(a_sd_lba), 64'd78);
      check("t1_sec_end", 64'(a_track_sec), 64'd12);
      check("t1_wait_end", 64'(a_cpu_wait), 64'd0);
      check("t2_lba_end", 64'(b_sd_lba), 64'd78);

      // Remount reload of track 5, head moves to 6 during sector 4.
      push_load(0, 0, 5);
      pulse_mount(2'b01);
      n = 0;
      while (!(a_busy && a_track_sec == 4'd4) && n < 300) begin @(negedge clk_sys); n++; end
      check("t3_at_sec4", 64'(a_track_sec), 64'd4);
      track[5:0] = 6'd6;
      push_load(0, 0, 6);
      wait_done("t3");
      check("t3_lba_end", 64'(a_sd_lba), 64'd91);

      // Both drives change together: drive 0 first, then drive 1.
      img_valid = 2'b11;
      track = {6'd2, 6'd7};
      push_load(0, 0, 7);
      push_load(1, 0, 2);
      n = 0;
      while (!(a_busy && a_cur_drive == 1'b1) && n < 3000) begin @(negedge clk_sys); n++; end
      check("t4_drive1_sel", 64'(a_cur_drive), 64'd1);
      check("t4_drive1_wait", 64'(a_cpu_wait), 64'd1);
      wait_done("t4");

      // Drive 1 without an image: no transfer, cur_track still follows.
      img_valid = 2'b01;
      track[11:6] = 6'd9;
      saw_busy = 0; saw_rd = 0; saw_wait = 0;
      repeat (12) begin
         @(negedge clk_sys);
         saw_busy |= a_busy; saw_rd |= a_sd_rd[1]; saw_wait |= a_cpu_wait;
      end
      check("t5_no_busy", 64'(saw_busy), 64'd0);
      check("t5_no_rd1", 64'(saw_rd), 64'd0);
      check("t5_no_wait", 64'(saw_wait), 64'd0);
      img_valid = 2'b11;
      saw_busy = 0;
      repeat (12) begin @(negedge clk_sys); saw_busy |= a_busy; end
      check("t5_track_latched", 64'(saw_busy), 64'd0);
      push_load(1, 0, 9);
      pulse_mount(2'b10);
      wait_busy("t5_mount");
      wait_done("t5_mount");
      check("t5_drive", 64'(a_cur_drive), 64'd1);

      // Dirty track 3 -> 4 on drive 0.
      track[5:0] = 6'd3;
      push_load(0, 0, 3);
      wait_busy("t6_pre");
      wait_done("t6_pre");
      clr_count = 0;
      dirty = 2'b01;
      track[5:0] = 6'd4;
`ifdef TRACK_WRITEBACK_EN
      push_load(0, 1, 3);
`endif
      push_load(0, 0, 4);
      wait_busy("t6");
      wait_done("t6");
`ifdef TRACK_WRITEBACK_EN
      check("t6_dirty_clr", 64'(clr_count), 64'd1);
`else
      check("t6_dirty_clr", 64'(clr_count), 64'd0);
`endif
      check("t6_wr_idle", 64'(a_sd_wr), 64'd0);

      // Asynchronous reset in the middle of a transfer.
      track[5:0] = 6'd5;
`ifdef TRACK_WRITEBACK_EN
      push_load(0, 1, 4);
`endif
      push_load(0, 0, 5);
      wait_busy("t7");
      tick(6);
`ifdef TRACK_WRITEBACK_EN
      check("t7_mid_flush", 64'(a_sd_wr), 64'd1);
`else
      check("t7_mid_read", 64'(a_sd_rd), 64'd1);
`endif
      #2 reset_n = 1'b0;
      #1;
      check("t7_rst_rd_wr", 64'({a_sd_rd, a_sd_wr}), 64'd0);
      check("t7_rst_wait_busy", 64'({a_cpu_wait, a_busy}), 64'd0);
      check("t7_rst_lba_sec", 64'({a_sd_lba, a_track_sec}), 64'd0);
      exp_q.delete();
      dirty = 2'b00;
      tick(3);
      // cur_track is back at 0, so both drives reload their current tracks.
      push_load(0, 0, 5);
      push_load(1, 0, 9);
      reset_n = 1'b1;
      wait_busy("t7_after");
      wait_done("t7_after");
      check("t7_lba_end", 64'(a_sd_lba), 64'd130);

      check("wait_tracks_busy", 64'(inv_err), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
